// File: rtl/bcd_stopwatch_pkg.sv
// Shared FSM encodings, active-low segment patterns and BCD increment helper for the stopwatch.
// Latency: n/a (types and pure functions); backpressure: n/a.
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Segment order abcdefg, bit 6 = a; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Returns {carry_out, digits + 1} with decimal ripple carry across four digits.
    function automatic logic [16:0] bcd_inc(input logic [15:0] d);
        logic        carry;
        logic [16:0] r;
        carry = 1'b1;
        r     = '0;
        for (int i = 0; i < 4; i++) begin
            if (carry && d[4*i +: 4] == 4'd9) begin
                r[4*i +: 4] = 4'd0;
            end else if (carry) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd1;
                carry       = 1'b0;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        r[16] = carry;
        return r;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_seg7_decode.sv
// BCD digit to active-low abcdefg segment pattern; codes above 9 blank the digit.
// Latency: combinational; backpressure: none.
module seg7_decode
    import bcd_stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// 4-digit BCD stopwatch counting rising edges of the divided clka wave, with multiplexed 7-seg drive.
// Latency: count updates on the edge after a tick, display regs 1 mclk behind scan/digits; backpressure: none.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int SCAN_W = 18,
    parameter int DP_POS = 2
) (
    input  logic        i_mclk,
    input  logic        i_clr,
    input  logic        i_clka,
    input  logic        i_start_stop,
    input  logic        i_clear,
    output logic [15:0] o_digits,
    output logic        o_running,
    output logic        o_wrap,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam logic [1:0]        DP_IDX   = DP_POS[1:0];
    localparam logic [SCAN_W-1:0] SCAN_ONE = 1;

    logic              r_clka_d;
    logic              w_tick;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_inc;
    logic [16:0]       w_inc_res;
    logic [15:0]       r_digits;
    logic              r_running;
    logic              r_wrap;
    logic [SCAN_W-1:0] r_scan;
    logic [1:0]        w_idx;
    logic [3:0]        w_dig;
    logic [6:0]        w_seg;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    // Loaded even during reset so a high clka at release is not seen as an edge.
    always_ff @(posedge i_mclk) begin
        r_clka_d <= i_clka;
    end

    assign w_tick = i_clka & ~r_clka_d;

    always_ff @(posedge i_mclk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (i_start_stop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // A tick is judged against the current state, so tick+start_stop in RUN still counts.
    assign w_inc     = w_tick & (r_state == ST_RUN) & ~i_clear;
    assign w_inc_res = bcd_inc(r_digits);

    assign w_idx = r_scan[SCAN_W-1:SCAN_W-2];
    assign w_dig = r_digits[{w_idx, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .i_bcd (w_dig),
        .o_seg (w_seg)
    );

    always_ff @(posedge i_mclk) begin
        if (i_clr) begin
            r_digits  <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_scan    <= '0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else begin
            if (i_clear) begin
                r_digits <= '0;
            end else if (w_inc) begin
                r_digits <= w_inc_res[15:0];
            end
            r_running <= (w_state_nxt == ST_RUN);
            r_wrap    <= w_inc & w_inc_res[16];
            r_scan    <= r_scan + SCAN_ONE;
            r_an      <= ~(4'b0001 << w_idx);
            r_seg     <= w_seg;
            r_dp      <= ~(w_idx == DP_IDX);
        end
    end

    assign o_digits  = r_digits;
    assign o_running = r_running;
    assign o_wrap    = r_wrap;
    assign o_an      = r_an;
    assign o_seg     = r_seg;
    assign o_dp      = r_dp;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with SCAN_W=4: reset, run/pause, wrap, priorities, display scan, mid-run clr.
// Latency: n/a; backpressure: n/a.
module tb_bcd_stopwatch;

    logic        mclk = 1'b0;
    logic        clr = 1'b1;
    logic        clka = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] o_digits;
    logic        o_running;
    logic        o_wrap;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;

    int checks   = 0;
    int errors   = 0;
    int scan_cnt = 0;
    int wrap_cnt = 0;

    logic [6:0] seg_tbl [10];
    int         dig_tbl [4];

    bcd_stopwatch #(.SCAN_W(4), .DP_POS(2)) dut (
        .i_mclk       (mclk),
        .i_clr        (clr),
        .i_clka       (clka),
        .i_start_stop (start_stop),
        .i_clear      (clear),
        .o_digits     (o_digits),
        .o_running    (o_running),
        .o_wrap       (o_wrap),
        .o_an         (o_an),
        .o_seg        (o_seg),
        .o_dp         (o_dp)
    );

    always #5 mclk = ~mclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    // scan_cnt counts non-reset edges; the DUT scan register equals it modulo 16.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            if (clr) scan_cnt = 0;
            else     scan_cnt++;
            #1;
            if (o_wrap) wrap_cnt++;
        end
    endtask

    task automatic clka_edges(input int n);
        for (int i = 0; i < n; i++) begin
            clka = 1'b0;
            step(2);
            clka = 1'b1;
            step(2);
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        int         idx;
        logic [3:0] exp_an;

        seg_tbl[0] = 7'b0000001; seg_tbl[1] = 7'b1001111; seg_tbl[2] = 7'b0010010;
        seg_tbl[3] = 7'b0000110; seg_tbl[4] = 7'b1001100; seg_tbl[5] = 7'b0100100;
        seg_tbl[6] = 7'b0100000; seg_tbl[7] = 7'b0001111; seg_tbl[8] = 7'b0000000;
        seg_tbl[9] = 7'b0000100;
        dig_tbl[0] = 4; dig_tbl[1] = 3; dig_tbl[2] = 2; dig_tbl[3] = 1;

        // 1: reset with clka held high
        step(3);
        clr = 1'b0;
        check_val("rst_digits", 32'(o_digits), 32'h0);
        check_val("rst_running", 32'(o_running), 32'h0);
        check_val("rst_wrap", 32'(o_wrap), 32'h0);
        check_val("rst_an", 32'(o_an), 32'hF);
        check_val("rst_seg", 32'(o_seg), 32'h7F);
        check_val("rst_dp", 32'(o_dp), 32'h1);
        step(1);
        check_val("first_an", 32'(o_an), 32'hE);
        step(2);
        check_val("no_spurious_tick", 32'(o_digits), 32'h0);

        // 2: run 12, pause, 5 ignored
        pulse_ss();
        check_val("start_running", 32'(o_running), 32'h1);
        clka_edges(12);
        check_val("count12", 32'(o_digits), 32'h0012);
        check_val("count12_running", 32'(o_running), 32'h1);
        pulse_ss();
        clka_edges(5);
        check_val("pause_hold", 32'(o_digits), 32'h0012);
        check_val("pause_running", 32'(o_running), 32'h0);

        // 3: full 10000-edge run with wrap
        pulse_clear();
        check_val("clear_digits", 32'(o_digits), 32'h0);
        check_val("clear_running", 32'(o_running), 32'h0);
        pulse_ss();
        wrap_cnt = 0;
        clka_edges(9999);
        check_val("count9999", 32'(o_digits), 32'h9999);
        check_val("no_early_wrap", 32'(wrap_cnt), 32'd0);
        clka = 1'b0;
        step(2);
        clka = 1'b1;
        step(1);
        check_val("wrap_digits", 32'(o_digits), 32'h0);
        check_val("wrap_pulse", 32'(o_wrap), 32'h1);
        step(1);
        check_val("wrap_drop", 32'(o_wrap), 32'h0);
        check_val("wrap_once", 32'(wrap_cnt), 32'd1);
        check_val("wrap_running", 32'(o_running), 32'h1);

        // 4: tick+start_stop in RUN, then clear+start_stop+tick
        clka_edges(41);
        check_val("count41", 32'(o_digits), 32'h0041);
        clka = 1'b0;
        step(2);
        clka = 1'b1;
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        check_val("tick_ss_digits", 32'(o_digits), 32'h0042);
        check_val("tick_ss_running", 32'(o_running), 32'h0);
        step(1);
        clka_edges(3);
        check_val("pause_ignore", 32'(o_digits), 32'h0042);
        pulse_ss();
        check_val("resume_running", 32'(o_running), 32'h1);
        clka = 1'b0;
        step(2);
        clka = 1'b1;
        clear = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear = 1'b0;
        start_stop = 1'b0;
        check_val("clr_all_digits", 32'(o_digits), 32'h0);
        check_val("clr_all_running", 32'(o_running), 32'h0);
        step(1);
        clka_edges(2);
        check_val("idle_ignore", 32'(o_digits), 32'h0);

        // 5: display scan of 1234
        pulse_ss();
        clka_edges(1234);
        pulse_ss();
        check_val("count1234", 32'(o_digits), 32'h1234);
        for (int c = 0; c < 16; c++) begin
            step(1);
            idx    = ((scan_cnt - 1) >> 2) & 3;
            exp_an = ~(4'b0001 << idx);
            check_val("scan_an", 32'(o_an), 32'(exp_an));
            check_val("scan_seg", 32'(o_seg), 32'(seg_tbl[dig_tbl[idx]]));
            check_val("scan_dp", 32'(o_dp), (idx == 2) ? 32'h0 : 32'h1);
        end

        // 6: clr mid-run
        pulse_clear();
        pulse_ss();
        clka_edges(357);
        check_val("count357", 32'(o_digits), 32'h0357);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_val("clr_digits", 32'(o_digits), 32'h0);
        check_val("clr_running", 32'(o_running), 32'h0);
        check_val("clr_an", 32'(o_an), 32'hF);
        check_val("clr_seg", 32'(o_seg), 32'h7F);
        check_val("clr_dp", 32'(o_dp), 32'h1);
        check_val("clr_wrap", 32'(o_wrap), 32'h0);
        clka_edges(2);
        check_val("clr_idle_ignore", 32'(o_digits), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
